// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and constants for the HI/LO execute unit
package muldiv_pkg;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    typedef enum logic [1:0] {IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} state_t;

    // Divide-by-zero yields an all-ones quotient; HI takes the dividend.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic int cnt_w(input int steps);
        return steps > 1 ? $clog2(steps) : 1;
    endfunction
endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX HI/LO-class bundle toward ex_muldiv and its results back
interface ex_muldiv_if;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic        stall_req_o;
    logic [31:0] result_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    modport master (output valid_i, aluop_i, reg1_i, reg2_i, flush_i,
                    input  stall_req_o, result_o, hi_o, lo_o);
    modport slave  (input  valid_i, aluop_i, reg1_i, reg2_i, flush_i,
                    output stall_req_o, result_o, hi_o, lo_o);
endinterface

// File: rtl/div_core.sv
// div_core: iterative restoring unsigned divider, one quotient bit per step
module div_core
    import muldiv_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = cnt_w(DIV_STEPS);

    logic [CW-1:0] cnt;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   dsr;
    logic [32:0]   sh;
    logic [32:0]   diff;

    // Trial subtract of the shifted partial remainder; bit 32 of diff is the borrow.
    always_comb begin
        sh        = {rem, quo[31]};
        diff      = sh - {1'b0, dsr};
        remainder = diff[32] ? sh[31:0] : diff[31:0];
        quotient  = {quo[30:0], ~diff[32]};
        last      = cnt == CW'(DIV_STEPS - 1);
    end

    // Load operands on start, then commit one step per busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dsr <= '0;
        end else if (start) begin
            cnt <= '0;
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            rem <= remainder;
            quo <= quotient;
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO owner doing MULT/MULTU, MTHI/MTLO, MFHI/MFLO and iterative DIV/DIVU
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input logic         clk,
    input logic         rst,
    ex_muldiv_if.slave  bus
);
    state_t      state;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        neg_q;
    logic        neg_r;
    logic        live;
    logic        is_div;
    logic        sgn;
    logic        early;
    logic        start;
    logic        last;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] sprod;
    logic [63:0] uprod;

    // Operand decode, magnitudes for the unsigned core, and the stall/read outputs.
    always_comb begin
        live   = bus.valid_i & ~bus.flush_i;
        is_div = bus.aluop_i == EXE_DIV_OP || bus.aluop_i == EXE_DIVU_OP;
        sgn    = bus.aluop_i == EXE_DIV_OP;
        a_abs  = sgn && bus.reg1_i[31] ? 32'd0 - bus.reg1_i : bus.reg1_i;
        b_abs  = sgn && bus.reg2_i[31] ? 32'd0 - bus.reg2_i : bus.reg2_i;
`ifdef DIV_EARLY_EXIT_EN
        early  = b_abs != 32'd0 && a_abs < b_abs;
`else
        early  = 1'b0;
`endif
        start  = state == IDLE && live && is_div && b_abs != 32'd0 && !early;
        sprod  = {{32{bus.reg1_i[31]}}, bus.reg1_i} * {{32{bus.reg2_i[31]}}, bus.reg2_i};
        uprod  = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};
        bus.stall_req_o = !bus.flush_i && (state == DIV_BUSY || (state == IDLE && bus.valid_i && is_div));
        bus.result_o = !live ? 32'd0 :
                       bus.aluop_i == EXE_MFHI_OP ? hi :
                       bus.aluop_i == EXE_MFLO_OP ? lo : 32'd0;
        bus.hi_o = hi;
        bus.lo_o = lo;
    end

    div_core #(.DIV_STEPS(DIV_STEPS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step      (state == DIV_BUSY),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .last      (last),
        .quotient  (q),
        .remainder (r)
    );

    // FSM plus HI/LO writes; a flush discards whatever the cycle would have written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (bus.flush_i) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (bus.valid_i && is_div && b_abs == 32'd0) begin
                state <= DIV_DONE;
                lo    <= DIV0_LO;
                hi    <= bus.reg1_i;
            end else if (bus.valid_i && is_div && early) begin
                state <= DIV_DONE;
                lo    <= '0;
                hi    <= bus.reg1_i;
            end else if (start) begin
                state <= DIV_BUSY;
                neg_q <= sgn & (bus.reg1_i[31] ^ bus.reg2_i[31]);
                neg_r <= sgn & bus.reg1_i[31];
            end else if (bus.valid_i && bus.aluop_i == EXE_MULT_OP) begin
                {hi, lo} <= sprod;
            end else if (bus.valid_i && bus.aluop_i == EXE_MULTU_OP) begin
                {hi, lo} <= uprod;
            end else if (bus.valid_i && bus.aluop_i == EXE_MTHI_OP) begin
                hi <= bus.reg1_i;
            end else if (bus.valid_i && bus.aluop_i == EXE_MTLO_OP) begin
                lo <= bus.reg1_i;
            end
        end else if (state == DIV_BUSY) begin
            if (last) begin
                state <= DIV_DONE;
                hi    <= neg_r ? 32'd0 - r : r;
                lo    <= neg_q ? 32'd0 - q : q;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    import muldiv_pkg::*;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        fl;
        logic [31:0] eh;
        logic [31:0] el;
        int          es;
    } vec_t;

`ifdef DIV_EARLY_EXIT_EN
    localparam int ES = 1;
`else
    localparam int ES = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    vec_t vt[14];

    ex_muldiv_if bus();

    ex_muldiv #(.DIV_STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic [31:0] eh, input logic [31:0] el, input int es);
        logic [63:0] e;
        int n;
        sb.push_back({eh, el});
        bus.valid_i = 1'b1;
        bus.aluop_i = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
        bus.flush_i = fl;
        n = 0;
        @(negedge clk);
        while (bus.stall_req_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_stalls"}, 32'(n), 32'(es));
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.aluop_i = 8'd0;
        e = sb.pop_front();
        chk({nm, "_hi"}, bus.hi_o, e[63:32]);
        chk({nm, "_lo"}, bus.lo_o, e[31:0]);
    endtask

    initial begin
        vt[0]  = '{EXE_MULT_OP,  32'hFFFFFFFE, 32'h3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
        vt[1]  = '{EXE_MULTU_OP, 32'hFFFFFFFE, 32'h3,        1'b0, 32'h00000002, 32'hFFFFFFFA, 0};
        vt[2]  = '{EXE_DIV_OP,   32'hFFFFFFF9, 32'h2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vt[3]  = '{EXE_DIVU_OP,  32'd100,      32'h0,        1'b0, 32'd100,      32'hFFFFFFFF, 1};
        vt[4]  = '{EXE_DIV_OP,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h80000000, 33};
        vt[5]  = '{EXE_MTHI_OP,  32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'h80000000, 0};
        vt[6]  = '{EXE_MTLO_OP,  32'h00000055, 32'h0,        1'b1, 32'h12345678, 32'h80000000, 0};
        vt[7]  = '{EXE_DIVU_OP,  32'd5,        32'd9,        1'b0, 32'd5,        32'd0,        ES};
        vt[8]  = '{EXE_DIVU_OP,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14,       33};
        vt[9]  = '{EXE_DIV_OP,   32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,        32'hFFFFFFFD, 33};
        vt[10] = '{EXE_DIV_OP,   32'hFFFFFFF8, 32'd3,        1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 33};
        vt[11] = '{EXE_MTLO_OP,  32'hAABBCCDD, 32'h0,        1'b0, 32'hFFFFFFFE, 32'hAABBCCDD, 0};
        vt[12] = '{EXE_DIV_OP,   32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        ES};
        vt[13] = '{EXE_DIV_OP,   32'hFFFFFFF9, 32'd0,        1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        bus.valid_i = 1'b0;
        bus.aluop_i = 8'd0;
        bus.reg1_i  = 32'd0;
        bus.reg2_i  = 32'd0;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_stall", 32'(bus.stall_req_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        for (int i = 0; i < 14; i++)
            run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].fl, vt[i].eh, vt[i].el, vt[i].es);
        run("mthi", EXE_MTHI_OP, 32'h12345678, 32'h0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 0);
        bus.valid_i = 1'b1;
        bus.aluop_i = EXE_MFHI_OP;
        #1;
        chk("mfhi", bus.result_o, 32'h12345678);
        bus.aluop_i = EXE_MFLO_OP;
        #1;
        chk("mflo", bus.result_o, 32'hFFFFFFFF);
        bus.flush_i = 1'b1;
        #1;
        chk("mflo_flush", bus.result_o, 32'd0);
        bus.flush_i = 1'b0;
        bus.aluop_i = EXE_MULT_OP;
        #1;
        chk("mult_result", bus.result_o, 32'd0);
        bus.valid_i = 1'b0;
        bus.aluop_i = EXE_MFHI_OP;
        #1;
        chk("invalid_result", bus.result_o, 32'd0);
        bus.aluop_i = 8'd0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b1;
        bus.aluop_i = EXE_DIVU_OP;
        bus.reg1_i  = 32'd100;
        bus.reg2_i  = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        chk("busy10_stall", 32'(bus.stall_req_o), 32'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall_req_o), 32'd0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_idle_stall", 32'(bus.stall_req_o), 32'd0);
        chk("flush_hi", bus.hi_o, 32'h12345678);
        chk("flush_lo", bus.lo_o, 32'hFFFFFFFF);
        repeat (30) @(posedge clk);
        #1;
        chk("flush_late_hi", bus.hi_o, 32'h12345678);
        chk("flush_late_lo", bus.lo_o, 32'hFFFFFFFF);
        run("post_flush_mult", EXE_MULT_OP, 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
